// File: rtl/addr_counter_pkg.sv
// Shared definitions for the multi-channel RAM address counter.
package addr_counter_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/addr_counter_lane.sv
// One address counter channel: stride stepping with wrap or saturate at a shared limit.
module addr_counter_lane
    import addr_counter_pkg::*;
#(
    parameter int CNT_W    = 9,
    parameter int STRIDE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                clear,
    input  logic                enable,
    input  logic                mode,
    input  logic [CNT_W-1:0]    limit,
    input  logic [STRIDE_W-1:0] stride,
    output logic [CNT_W-1:0]    cnt,
    output logic                wrap_pulse,
    output logic                done
);

    localparam int XW = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic [XW-1:0]    step;
    logic [XW-1:0]    nxt;

    // The sum carries one extra bit so a step past the top of the range is seen as > limit.
    always_comb begin
        step   = (stride == '0) ? XW'(1) : XW'(stride);
        nxt    = XW'(cnt_q) + step;
        cnt_d  = cnt_q;
        done_d = done_q;
        wrap_d = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (clear) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (enable && !done_q) begin
            if (nxt <= XW'(limit)) begin
                cnt_d = nxt[CNT_W-1:0];
            end else begin
                case (mode)
                    MODE_WRAP: begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                    MODE_SAT: begin
                        cnt_d  = limit;
                        done_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt        = cnt_q;
    assign done       = done_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/addr_counter_ch.sv
// Multi-channel RAM address generator: shared init/run FSM feeding NUM_CH independent counter lanes.
module addr_counter_ch
    import addr_counter_pkg::*;
#(
    parameter  int RAM_ADDR_WIDTH = 7,
    parameter  int NUM_CH         = 2,
    parameter  int STRIDE_W       = 4,
    localparam int CNT_W          = RAM_ADDR_WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    asyn_reset_n,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       enable,
    input  logic                    mode,
    input  logic [CNT_W-1:0]        limit,
    input  logic [STRIDE_W-1:0]     stride,
    output logic                    ready,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic [NUM_CH-1:0]       wrap_pulse,
    output logic [NUM_CH-1:0]       done
);

    state_e state_q, state_d;
    logic   run;

    // One init cycle after reset release keeps every counter at zero before counting starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign run   = (state_q == S_RUN);
    assign ready = run;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        addr_counter_lane #(
            .CNT_W    (CNT_W),
            .STRIDE_W (STRIDE_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (asyn_reset_n),
            .run        (run),
            .clear      (clear),
            .enable     (enable[k]),
            .mode       (mode),
            .limit      (limit),
            .stride     (stride),
            .cnt        (cnt[k*CNT_W +: CNT_W]),
            .wrap_pulse (wrap_pulse[k]),
            .done       (done[k])
        );
    end

endmodule
